// File: rtl/pro_display_ctrl_if.sv
// Processor-core side bundle of the operator/display sequencer.
//   master : the sequencer (drives operand config, start, mem_addr, busy)
//   slave  : the processor core (returns result/ovf and memory read data)
// Signals:
//   start        single-cycle start pulse to the core
//   busy         high while the core is running an operation
//   sar1/sar2    latched source register addresses
//   dar          latched destination register address
//   opcode       latched opcode
//   alu_mode     latched {1'b0, sw[5], opcode}
//   out_mode     latched output mode (1 = browse memory after result)
//   mem_addr     memory browse address
//   result_valid single-cycle pulse qualifying alu_result/ovf
//   alu_result   core result
//   ovf          core overflow flag
//   mem_rd_data  memory read data for mem_addr (combinational from core)
interface pro_display_ctrl_if;
  logic        start;
  logic        busy;
  logic [3:0]  sar1;
  logic [3:0]  sar2;
  logic [3:0]  dar;
  logic [1:0]  opcode;
  logic [2:0]  alu_mode;
  logic        out_mode;
  logic [3:0]  mem_addr;
  logic        result_valid;
  logic [15:0] alu_result;
  logic        ovf;
  logic [15:0] mem_rd_data;

  modport master (
    output start, busy, sar1, sar2, dar, opcode, alu_mode, out_mode, mem_addr,
    input  result_valid, alu_result, ovf, mem_rd_data
  );

  modport slave (
    input  start, busy, sar1, sar2, dar, opcode, alu_mode, out_mode, mem_addr,
    output result_valid, alu_result, ovf, mem_rd_data
  );
endinterface

// File: rtl/pro_display_ctrl.sv
// Operator/display sequencer: walks the operator through operand entry with
// the slide switches and the Next key, starts the core, captures its result
// and drives the 7-segment decoder through done/overflow message, result
// display and memory browse phases.
// Ports:
//   clk_50M      system clock
//   rst          synchronous reset, active-high
//   key_next     debounced single-cycle Next pulse
//   sw           slide switches
//   core         core-side bundle (master modport)
//   ts           decoder type select (registered, follows state by one cycle)
//   display_data decoder value (registered)
module pro_display_ctrl #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                     clk_50M,
  input  logic                     rst,
  input  logic                     key_next,
  input  logic [9:0]               sw,
  pro_display_ctrl_if.master       core,
  output logic [2:0]               ts,
  output logic [15:0]              display_data
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // State codes double as the decoder type-select values.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    DONE = 3'b001,
    OVF  = 3'b010,
    RUN  = 3'b011,
    SRC  = 3'b100,
    DST  = 3'b101,
    DATA = 3'b110,
    MEM  = 3'b111
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [15:0]      result_q;
  logic             hold_exit_c;

  // Leave a message phase on hold expiry or Next; both together still give one move.
  assign hold_exit_c = (hold_cnt == HOLD_LAST) || key_next;

  // Sequencer, latched configuration and display registers.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      result_q      <= '0;
      ts            <= 3'b000;
      display_data  <= '0;
      core.start    <= 1'b0;
      core.busy     <= 1'b0;
      core.sar1     <= '0;
      core.sar2     <= '0;
      core.dar      <= '0;
      core.opcode   <= '0;
      core.alu_mode <= '0;
      core.out_mode <= 1'b0;
      core.mem_addr <= '0;
    end else begin
      core.start <= 1'b0;

      // Display follows the state it was in at this edge.
      ts <= state;
      case (state)
        SRC, DST, RUN: display_data <= {6'b0, sw};
        DATA:          display_data <= result_q;
        MEM:           display_data <= core.mem_rd_data;
        default:       display_data <= '0;
      endcase

      case (state)
        IDLE: begin
          if (key_next) state <= SRC;
        end

        SRC: begin
          if (key_next) begin
            core.sar1   <= sw[9:6];
            core.sar2   <= sw[5:2];
            core.opcode <= sw[1:0];
            state       <= DST;
          end
        end

        DST: begin
          if (key_next) begin
            core.dar      <= sw[4:1];
            core.alu_mode <= {1'b0, sw[5], core.opcode};
            core.out_mode <= sw[0];
            core.start    <= 1'b1;
            core.busy     <= 1'b1;
            state         <= RUN;
          end
        end

        // Next is deliberately ignored while the core is busy.
        RUN: begin
          if (core.result_valid) begin
            result_q  <= core.alu_result;
            hold_cnt  <= '0;
            core.busy <= 1'b0;
            state     <= core.ovf ? OVF : DONE;
          end
        end

        DONE, OVF: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + CNT_W'(1);
          if (hold_exit_c) state <= (state == DONE) ? DATA : IDLE;
        end

        DATA: begin
          if (key_next) state <= core.out_mode ? MEM : IDLE;
        end

        MEM: begin
          core.mem_addr <= sw[3:0];
          if (key_next) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pro_display_ctrl.sv
// Bench for pro_display_ctrl: scenario tasks with randomized operands and
// results, checked against an arithmetic model of the operator flow.
module tb_pro_display_ctrl;
  localparam int unsigned HOLD = 8;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        key_next = 1'b0;
  logic [9:0]  sw = '0;
  logic [2:0]  ts;
  logic [15:0] display_data;

  logic [15:0] mem_model [16];
  int checks = 0;
  int errors = 0;

  // Expected latched configuration.
  logic [3:0] m_sar1, m_sar2, m_dar;
  logic [1:0] m_op;
  logic [2:0] m_mode;
  logic       m_out;

  pro_display_ctrl_if bus();
  assign bus.mem_rd_data = mem_model[bus.mem_addr];

  pro_display_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
    .clk_50M      (clk_50M),
    .rst          (rst),
    .key_next     (key_next),
    .sw           (sw),
    .core         (bus.master),
    .ts           (ts),
    .display_data (display_data)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic press();
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
  endtask

  // Operand entry from IDLE through to the first RUN cycle.
  task automatic enter(input logic [9:0] s_src, input logic [9:0] s_dst);
    press();
    sw = s_src;
    tick();
    checks++; if (ts !== 3'b100) begin errors++; $display("FAIL src_ts got %b exp %b", ts, 3'b100); end
    checks++; if (display_data !== {6'b0, s_src}) begin errors++; $display("FAIL src_disp got %h exp %h", display_data, {6'b0, s_src}); end
    press();
    m_sar1 = 4'(s_src / 10'd64);
    m_sar2 = 4'((s_src / 10'd4) % 10'd16);
    m_op   = 2'(s_src % 10'd4);
    m_dar  = 4'((s_dst / 10'd2) % 10'd16);
    m_mode = 3'(((s_dst / 10'd32) % 10'd2) * 10'd4 + 10'(m_op));
    m_out  = 1'(s_dst % 10'd2);
    sw = s_dst;
    press();
    checks++; if (bus.start !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL start_rise got start=%b busy=%b exp 1 1", bus.start, bus.busy); end
    tick();
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL start_width got %b exp 0", bus.start); end
    checks++; if (ts !== 3'b011) begin errors++; $display("FAIL run_ts got %b exp 011", ts); end
    checks++;
    if (bus.sar1 !== m_sar1 || bus.sar2 !== m_sar2 || bus.opcode !== m_op ||
        bus.dar !== m_dar || bus.alu_mode !== m_mode || bus.out_mode !== m_out) begin
      errors++;
      $display("FAIL config got %h %h %h %h %h %h exp %h %h %h %h %h %h",
               bus.sar1, bus.sar2, bus.opcode, bus.dar, bus.alu_mode, bus.out_mode,
               m_sar1, m_sar2, m_op, m_dar, m_mode, m_out);
    end
  endtask

  task automatic give_result(input logic [15:0] r, input logic o);
    bus.alu_result = r;
    bus.ovf = o;
    bus.result_valid = 1'b1;
    tick();
    bus.result_valid = 1'b0;
    bus.alu_result = 16'($urandom);
    bus.ovf = 1'($urandom);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_clear got %b exp 0", bus.busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ts !== 3'b000 || display_data !== 16'h0 || bus.start !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sar1 !== 4'h0 || bus.sar2 !== 4'h0 || bus.dar !== 4'h0 || bus.opcode !== 2'h0 ||
        bus.alu_mode !== 3'h0 || bus.out_mode !== 1'b0 || bus.mem_addr !== 4'h0) begin
      errors++;
      $display("FAIL reset got ts=%b disp=%h start=%b busy=%b sar1=%h sar2=%h dar=%h op=%h mode=%h out=%b addr=%h exp all 0",
               ts, display_data, bus.start, bus.busy, bus.sar1, bus.sar2, bus.dar, bus.opcode,
               bus.alu_mode, bus.out_mode, bus.mem_addr);
    end
    rst = 1'b0;
    tick();
    checks++; if (ts !== 3'b000) begin errors++; $display("FAIL reset_idle got %b exp 000", ts); end
  endtask

  task automatic test_entry();
    enter(10'b1010011011, 10'b0000101101);
  endtask

  task automatic test_key_in_run();
    press();
    press();
    tick();
    checks++; if (ts !== 3'b011 || bus.busy !== 1'b1) begin errors++; $display("FAIL key_in_run got ts=%b busy=%b exp 011 1", ts, bus.busy); end
  endtask

  task automatic test_done_path();
    int n = 0;
    give_result(16'd12345, 1'b0);
    for (int c = 0; c < int'(HOLD); c++) begin
      tick();
      if (ts === 3'b001) n++;
    end
    checks++; if (n != int'(HOLD)) begin errors++; $display("FAIL done_hold got %0d exp %0d", n, HOLD); end
    tick();
    checks++; if (ts !== 3'b110 || display_data !== 16'd12345) begin errors++; $display("FAIL data_disp got ts=%b disp=%0d exp 110 12345", ts, display_data); end
    // A stray result outside RUN must not touch the held result.
    bus.alu_result = 16'd999;
    bus.result_valid = 1'b1;
    tick();
    bus.result_valid = 1'b0;
    tick();
    tick();
    checks++; if (ts !== 3'b110 || display_data !== 16'd12345) begin errors++; $display("FAIL data_hold got ts=%b disp=%0d exp 110 12345", ts, display_data); end
  endtask

  task automatic test_mem_browse();
    logic [3:0] a;
    press();
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 4'd7 : 4'($urandom);
      sw = {6'($urandom), a};
      tick();
      tick();
      tick();
      checks++;
      if (bus.mem_addr !== a || ts !== 3'b111 || display_data !== mem_model[a]) begin
        errors++;
        $display("FAIL mem_browse got addr=%h ts=%b disp=%h exp %h 111 %h", bus.mem_addr, ts, display_data, a, mem_model[a]);
      end
    end
    press();
    tick();
    checks++; if (ts !== 3'b000 || display_data !== 16'h0) begin errors++; $display("FAIL mem_exit got ts=%b disp=%h exp 000 0", ts, display_data); end
  endtask

  task automatic test_result_in_idle();
    bus.alu_result = 16'($urandom);
    bus.ovf = 1'b0;
    bus.result_valid = 1'b1;
    tick();
    bus.result_valid = 1'b0;
    tick();
    tick();
    checks++; if (ts !== 3'b000 || display_data !== 16'h0) begin errors++; $display("FAIL idle_result got ts=%b disp=%h exp 000 0", ts, display_data); end
    checks++; if (bus.sar1 !== m_sar1 || bus.dar !== m_dar) begin errors++; $display("FAIL idle_config got %h %h exp %h %h", bus.sar1, bus.dar, m_sar1, m_dar); end
  endtask

  task automatic test_ovf_path();
    enter(10'($urandom), 10'($urandom));
    give_result(16'($urandom), 1'b1);
    tick();
    checks++; if (ts !== 3'b010) begin errors++; $display("FAIL ovf_ts1 got %b exp 010", ts); end
    tick();
    checks++; if (ts !== 3'b010) begin errors++; $display("FAIL ovf_ts2 got %b exp 010", ts); end
    press();
    tick();
    checks++; if (ts !== 3'b000 || display_data !== 16'h0) begin errors++; $display("FAIL ovf_exit got ts=%b disp=%h exp 000 0", ts, display_data); end
    tick();
    tick();
    checks++; if (ts !== 3'b000) begin errors++; $display("FAIL ovf_no_data got %b exp 000", ts); end
  endtask

  task automatic test_coincident();
    logic [15:0] r;
    bit ok;
    // DONE: Next on the expiry edge moves only to DATA.
    r = 16'($urandom);
    enter(10'($urandom), 10'($urandom) & 10'h3FE);
    give_result(r, 1'b0);
    for (int c = 1; c < int'(HOLD); c++) tick();
    press();
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ts !== 3'b110 || display_data !== r) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL coinc_done got ts=%b disp=%h exp 110 %h", ts, display_data, r); end
    press();
    // OVF: Next on the expiry edge moves only to IDLE.
    enter(10'($urandom), 10'($urandom));
    give_result(16'($urandom), 1'b1);
    for (int c = 1; c < int'(HOLD); c++) tick();
    press();
    ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ts !== 3'b000) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL coinc_ovf got ts=%b exp 000", ts); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    enter(10'($urandom) | 10'h040, 10'($urandom));
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (ts !== 3'b000 || bus.sar1 !== 4'h0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_run got ts=%b sar1=%h busy=%b exp 000 0 0", ts, bus.sar1, bus.busy); end
    m_sar1 = '0; m_sar2 = '0; m_op = '0; m_dar = '0; m_mode = '0; m_out = 1'b0;
    bus.alu_result = 16'($urandom);
    bus.result_valid = 1'b1;
    tick();
    bus.result_valid = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ts !== 3'b000 || bus.start !== 1'b0) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_run_after got ts=%b start=%b exp 000 0", ts, bus.start); end
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic        o;
    int          k, n, lim;
    logic [2:0]  hold_code;
    for (int it = 0; it < 8; it++) begin
      r = 16'($urandom);
      o = 1'($urandom);
      k = int'($urandom_range(1, 10));
      enter(10'($urandom), 10'($urandom));
      give_result(r, o);
      hold_code = o ? 3'b010 : 3'b001;
      lim = (k < int'(HOLD)) ? k : int'(HOLD);
      n = 0;
      for (int c = 1; c <= int'(HOLD); c++) begin
        if (c == k) press(); else tick();
        if (ts === hold_code) n++;
        if (c == k) break;
      end
      checks++; if (n != lim) begin errors++; $display("FAIL rnd_hold it=%0d got %0d exp %0d", it, n, lim); end
      tick();
      checks++;
      if (ts !== (o ? 3'b000 : 3'b110) || display_data !== (o ? 16'h0 : r)) begin
        errors++;
        $display("FAIL rnd_after it=%0d got ts=%b disp=%h exp %b %h", it, ts, display_data, o ? 3'b000 : 3'b110, o ? 16'h0 : r);
      end
      if (!o) begin
        press();
        if (m_out) begin
          tick();
          checks++; if (ts !== 3'b111) begin errors++; $display("FAIL rnd_mem it=%0d got %b exp 111", it, ts); end
          press();
        end
      end
      tick();
      checks++; if (ts !== 3'b000) begin errors++; $display("FAIL rnd_idle it=%0d got %b exp 000", it, ts); end
    end
  endtask

  initial begin
    bus.result_valid = 1'b0;
    bus.alu_result = '0;
    bus.ovf = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = 16'($urandom);
    mem_model[7] = 16'hBEEF;
    test_reset();
    test_entry();
    test_key_in_run();
    test_done_path();
    test_mem_browse();
    test_result_in_idle();
    test_ovf_path();
    test_coincident();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
